// File: rtl/mem_if_pkg.sv
// Shared types and constants for the data-memory responder: size codes,
// FSM states and the latched request payload.
package mem_if_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    size_e           size;
    logic            sgn;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

  // True when the access does not sit on its natural boundary.
  function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return lo[0];
      SZ_WORD: return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering between the 32-bit RAM word and right-justified CPU data:
// store byte enables / replicated write word, and load select plus extension.
module lane_align
  import mem_if_pkg::*;
(
  input  logic [1:0]      i_addr_lo,
  input  size_e           i_size,
  input  logic            i_sgn,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rword,
  output logic [3:0]      o_be_c,
  output logic [XLEN-1:0] o_wword_c,
  output logic [XLEN-1:0] o_ldata_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store: replicate the data across all lanes, the enables pick the target bytes.
  always_comb begin : store_path
    o_be_c    = 4'b0000;
    o_wword_c = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_be_c    = 4'b0001 << i_addr_lo;
        o_wword_c = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_be_c    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wword_c = {2{i_wdata[15:0]}};
      end
      SZ_WORD: o_be_c = 4'b1111;
      default: o_be_c = 4'b0000;
    endcase
  end

  // Load: pick the addressed lane, then sign- or zero-extend.
  always_comb begin : load_path
    w_byte    = i_rword[{i_addr_lo, 3'b000} +: 8];
    w_half    = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
    o_ldata_c = '0;
    case (i_size)
      SZ_BYTE: o_ldata_c = {{24{i_sgn & w_byte[7]}}, w_byte};
      SZ_HALF: o_ldata_c = {{16{i_sgn & w_half[15]}}, w_half};
      SZ_WORD: o_ldata_c = i_rword;
      default: o_ldata_c = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the core's data-memory port: one outstanding request,
// programmable wait states, word RAM with byte-lane stores and checked addresses.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned       IDX_W     = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [WAIT_W-1:0] r_cnt;
  logic [WAIT_W-1:0] w_cnt_nxt;
  mem_req_t          r_req;
  mem_req_t          w_in_req;
  mem_req_t          w_acc_req;
  logic [29:0]       w_idx;
  logic              w_err;
  logic              w_accept;
  logic              w_access;
  logic [3:0]        w_be;
  logic [XLEN-1:0]   w_wword;
  logic [XLEN-1:0]   w_ldata;
  logic [XLEN-1:0]   w_rword;
  logic [XLEN-1:0]   r_ram [ADDR_WORDS];

  assign w_in_req = '{we: req_we, addr: req_addr, size: size_e'(req_size),
                      sgn: req_signed, wdata: req_wdata};

  // Zero-wait accesses happen on the accept edge, before the request is latched.
  assign w_acc_req = (r_state == IDLE) ? w_in_req : r_req;
  assign w_idx     = 30'((w_acc_req.addr - BASE_ADDR) >> 2);
  assign w_accept  = (r_state == IDLE) && req_valid;

  assign w_err = (w_in_req.size == SZ_RSVD)
               | misaligned(w_in_req.size, w_in_req.addr[1:0])
               | (w_in_req.addr < BASE_ADDR)
               | (32'(w_idx) >= 32'(ADDR_WORDS));

  assign w_rword = r_ram[w_idx[IDX_W-1:0]];

  lane_align u_lane_align (
    .i_addr_lo (w_acc_req.addr[1:0]),
    .i_size    (w_acc_req.size),
    .i_sgn     (w_acc_req.sgn),
    .i_wdata   (w_acc_req.wdata),
    .i_rword   (w_rword),
    .o_be_c    (w_be),
    .o_wword_c (w_wword),
    .o_ldata_c (w_ldata)
  );

  // Next state, wait counter and the access strobe.
  always_comb begin : fsm_next
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_access    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_err) begin
            w_state_nxt = RESP;
          end else if (WAIT_CYCLES == 0) begin
            w_access    = 1'b1;
            w_state_nxt = RESP;
          end else begin
            w_cnt_nxt   = WAIT_INIT;
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == WAIT_W'(1)) begin
          w_access    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - WAIT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, latched request and registered handshake/response outputs.
  always_ff @(posedge clk) begin : ctrl_regs
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_req      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      req_ready  <= (w_state_nxt == IDLE);
      resp_valid <= (w_state_nxt == RESP);
      if (w_accept) begin
        r_req      <= w_in_req;
        resp_err   <= w_err;
        resp_rdata <= '0;
      end
      if (w_access) resp_rdata <= w_acc_req.we ? '0 : w_ldata;
    end
  end

  // Word RAM; stores touch only the enabled byte lanes.
  always_ff @(posedge clk) begin : ram_write
    if (reset) begin
      for (int unsigned i = 0; i < ADDR_WORDS; i++) r_ram[i] <= '0;
    end else if (w_access && w_acc_req.we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) r_ram[w_idx[IDX_W-1:0]][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance with one wait state,
// one with three wait states for the reset-in-WAIT scenario.
module tb_data_mem_responder;
  import mem_if_pkg::*;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  logic        clk;
  logic        rst1, rst3, sel3;
  logic        req_valid, req_we, req_signed, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rdy1, v1, e1, rdy3, v3, e3;
  logic [31:0] rd1, rd3;
  logic        m_ready, m_valid, m_err;
  logic [31:0] m_rdata;

  exp_t q[$];
  int   ntests = 0;
  int   nfail  = 0;

  data_mem_responder #(.ADDR_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .reset(rst1), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .resp_valid(v1), .resp_ready(resp_ready), .resp_rdata(rd1), .resp_err(e1));

  data_mem_responder #(.ADDR_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(rst3), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .resp_valid(v3), .resp_ready(resp_ready), .resp_rdata(rd3), .resp_err(e3));

  assign m_ready = sel3 ? rdy3 : rdy1;
  assign m_valid = sel3 ? v3   : v1;
  assign m_rdata = sel3 ? rd3  : rd1;
  assign m_err   = sel3 ? e3   : e1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive a request until accepted and queue what the response must be.
  task automatic send(input logic we, input logic [31:0] a, input logic [1:0] sz,
                      input logic sg, input logic [31:0] wd,
                      input logic [31:0] erd, input logic eerr, input int elat);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
    req_signed = sg; req_wdata = wd;
    while (m_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      ntests++; nfail++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", m_ready, n);
    end
    q.push_back('{erd, eerr, 8'(elat)});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Cycles from the accept cycle until resp_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (m_valid !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic xfer(input logic we, input logic [31:0] a, input logic [1:0] sz,
                      input logic sg, input logic [31:0] wd,
                      input logic [31:0] erd, input logic eerr, input int elat,
                      output exp_t obs, output exp_t exp);
    int lat;
    send(we, a, sz, sg, wd, erd, eerr, elat);
    wait_valid(lat);
    obs = '{m_rdata, m_err, 8'(lat)};
    exp = q.pop_front();
    handshake();
  endtask

  task automatic test_reset();
    rst1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst1 = 1'b0;
    @(posedge clk); #1;
    ntests++;
    if ({m_ready, m_valid} !== 2'b10) begin
      nfail++;
      $display("FAIL reset_handshake: ready/valid=%b, required 10", {m_ready, m_valid});
    end
    ntests++;
    if ({m_rdata, m_err} !== 33'h0) begin
      nfail++;
      $display("FAIL reset_resp: rdata=%h err=%b, required 0/0", m_rdata, m_err);
    end
  endtask

  task automatic test_load_zero();
    exp_t o, e;
    xfer(1'b0, 32'h0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 2, o, e);
    ntests++;
    if (o !== e) begin
      nfail++;
      $display("FAIL load_zero: rd=%h err=%b lat=%0d, required rd=%h err=%b lat=%0d",
               o.rd, o.err, o.lat, e.rd, e.err, e.lat);
    end
  endtask

  task automatic test_ext_loads();
    exp_t o, e;
    logic [31:0] a  [6] = '{32'h13, 32'h10, 32'h12, 32'h13, 32'h11, 32'h10};
    logic [1:0]  sz [6] = '{SZ_BYTE, SZ_HALF, SZ_HALF, SZ_BYTE, SZ_BYTE, SZ_WORD};
    logic        sg [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] ex [6] = '{32'hFFFF_FF87, 32'h0000_4321, 32'hFFFF_8765,
                            32'h0000_0087, 32'h0000_0043, 32'h8765_4321};
    xfer(1'b1, 32'h10, SZ_WORD, 1'b0, 32'h8765_4321, 32'h0, 1'b0, 2, o, e);
    ntests++;
    if (o !== e) begin
      nfail++;
      $display("FAIL store_word: rd=%h err=%b lat=%0d, required rd=%h err=%b lat=%0d",
               o.rd, o.err, o.lat, e.rd, e.err, e.lat);
    end
    for (int i = 0; i < 6; i++) begin
      xfer(1'b0, a[i], sz[i], sg[i], 32'h0, ex[i], 1'b0, 2, o, e);
      ntests++;
      if (o !== e) begin
        nfail++;
        $display("FAIL ext_load[%0d]: rd=%h err=%b lat=%0d, required rd=%h err=%b lat=%0d",
                 i, o.rd, o.err, o.lat, e.rd, e.err, e.lat);
      end
    end
  endtask

  task automatic test_byte_merge();
    exp_t o, e;
    logic        we [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] a  [5] = '{32'h20, 32'h21, 32'h20, 32'h26, 32'h24};
    logic [1:0]  sz [5] = '{SZ_WORD, SZ_BYTE, SZ_WORD, SZ_HALF, SZ_WORD};
    logic [31:0] wd [5] = '{32'h1122_3344, 32'h0000_00AB, 32'h0, 32'h0000_BEEF, 32'h0};
    logic [31:0] ex [5] = '{32'h0, 32'h0, 32'h1122_AB44, 32'h0, 32'hBEEF_0000};
    for (int i = 0; i < 5; i++) begin
      xfer(we[i], a[i], sz[i], 1'b0, wd[i], ex[i], 1'b0, 2, o, e);
      ntests++;
      if (o !== e) begin
        nfail++;
        $display("FAIL byte_merge[%0d]: rd=%h err=%b lat=%0d, required rd=%h err=%b lat=%0d",
                 i, o.rd, o.err, o.lat, e.rd, e.err, e.lat);
      end
    end
  endtask

  task automatic test_errors();
    exp_t o, e;
    logic        we [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] a  [6] = '{32'h22, 32'h11, 32'h0, 32'h1000, 32'hFFFF_FFFC, 32'h10};
    logic [1:0]  sz [6] = '{SZ_WORD, SZ_HALF, 2'b11, SZ_WORD, SZ_WORD, SZ_WORD};
    logic        er [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] ex [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8765_4321};
    int          lt [6] = '{1, 1, 1, 1, 1, 2};
    for (int i = 0; i < 6; i++) begin
      xfer(we[i], a[i], sz[i], 1'b0, 32'hFFFF_FFFF, ex[i], er[i], lt[i], o, e);
      ntests++;
      if (o !== e) begin
        nfail++;
        $display("FAIL error_case[%0d]: rd=%h err=%b lat=%0d, required rd=%h err=%b lat=%0d",
                 i, o.rd, o.err, o.lat, e.rd, e.err, e.lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    logic ok;
    send(1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, 32'h8765_4321, 1'b0, 2);
    wait_valid(lat);
    e = q.pop_front();
    ntests++;
    if (m_rdata !== e.rd || m_err !== e.err || lat != int'(e.lat)) begin
      nfail++;
      $display("FAIL hold_first: rd=%h err=%b lat=%0d, required rd=%h err=%b lat=%0d",
               m_rdata, m_err, lat, e.rd, e.err, e.lat);
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_size = SZ_WORD; req_signed = 1'b0;
    ok = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (m_valid !== 1'b1 || m_rdata !== e.rd || m_err !== e.err || m_ready !== 1'b0) ok = 1'b0;
    end
    ntests++;
    if (ok !== 1'b1) begin
      nfail++;
      $display("FAIL hold_stable: valid=%b rd=%h ready=%b, required 1/%h/0",
               m_valid, m_rdata, m_ready, e.rd);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    ntests++;
    if ({m_ready, m_valid} !== 2'b10) begin
      nfail++;
      $display("FAIL hold_release: ready/valid=%b, required 10", {m_ready, m_valid});
    end
    q.push_back('{32'h1122_AB44, 1'b0, 8'd2});
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_valid(lat);
    e = q.pop_front();
    ntests++;
    if (m_rdata !== e.rd || m_err !== e.err || lat != int'(e.lat)) begin
      nfail++;
      $display("FAIL hold_second: rd=%h err=%b lat=%0d, required rd=%h err=%b lat=%0d",
               m_rdata, m_err, lat, e.rd, e.err, e.lat);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    exp_t o, e;
    logic seen;
    rst1 = 1'b1;
    sel3 = 1'b1;
    @(negedge clk); rst3 = 1'b0;
    xfer(1'b0, 32'h0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 4, o, e);
    ntests++;
    if (o !== e) begin
      nfail++;
      $display("FAIL wait3_load: rd=%h err=%b lat=%0d, required rd=%h err=%b lat=%0d",
               o.rd, o.err, o.lat, e.rd, e.err, e.lat);
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_size = SZ_WORD;
    req_signed = 1'b0; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (m_valid !== 1'b0 || m_ready !== 1'b1) seen = 1'b1;
    end
    ntests++;
    if (seen !== 1'b0) begin
      nfail++;
      $display("FAIL reset_mid_idle: stray valid or ready low after reset, valid=%b ready=%b, required 0/1",
               m_valid, m_ready);
    end
    xfer(1'b0, 32'h30, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 4, o, e);
    ntests++;
    if (o !== e) begin
      nfail++;
      $display("FAIL reset_mid_load: rd=%h err=%b lat=%0d, required rd=%h err=%b lat=%0d",
               o.rd, o.err, o.lat, e.rd, e.err, e.lat);
    end
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; sel3 = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_signed = 1'b0; req_wdata = '0; resp_ready = 1'b0;
    test_reset();
    test_load_zero();
    test_ext_loads();
    test_byte_merge();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the processor's data-memory interface. It serves load and store requests issued by the core's memory stage over a valid/ready handshake.
- Owns a word-organised RAM, little-endian, with a configurable wait-state count.
- Performs byte, halfword and word lane steering, load sign/zero extension, and alignment and range checking.
- Sits between the CPU datapath and the memory, and replaces the combinational data memory once the core tolerates stalls.

Parameters:
- ADDR_WORDS, 1024: RAM depth in 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- WAIT_CYCLES, 1: extra cycles between accept and access. Legal range is 0..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_signed  in  1  load extension: 1 = sign, 0 = zero. Ignored on stores.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  requester takes the response.
- resp_rdata  out  32  extended load data. 0 for stores and errors.
- resp_err  out  1  request rejected.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All state updates on the rising edge of clk.
- Reset values:
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, wait counter = 0.
  - All RAM words are cleared to 0.
- FSM states: IDLE, WAIT, RESP. One outstanding request at a time.
- req_ready = 1 only in IDLE. An accept occurs on an edge where state = IDLE and req_valid = 1.
  - The request fields (we, addr, size, signed, wdata) are latched at accept.
- Error check at accept. Any of the following sets err and suppresses the access entirely:
  - req_size = 11.
  - Half with addr[0] = 1.
  - Word with addr[1:0] != 0.
  - addr < BASE_ADDR.
  - (addr - BASE_ADDR) >> 2 >= ADDR_WORDS.
- Transitions out of IDLE on accept:
  - Error: go to RESP. resp_valid rises the next cycle, resp_err = 1, resp_rdata = 0.
  - No error, WAIT_CYCLES = 0: the access happens on the accept edge. Go to RESP.
  - No error, WAIT_CYCLES > 0: load the counter with WAIT_CYCLES and go to WAIT.
- WAIT: the counter decrements each cycle. On the edge where counter = 1, the access is performed and the state goes to RESP.
- Latency: resp_valid is asserted exactly WAIT_CYCLES + 1 cycles after the accept edge.
- Store access:
  - Byte lane = addr[1:0]. Half lane = addr[1] (bytes {2,3} or {0,1}).
  - Only the addressed bytes change; the other bytes of the word are preserved.
  - The response has resp_rdata = 0 and resp_err = 0.
- Load access:
  - Select the addressed byte, half or word, then sign- or zero-extend per the latched signed bit.
  - Register the result into resp_rdata.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_ready = 1.
  - On that edge: resp_valid goes to 0 and the state goes to IDLE.
  - The earliest next accept is the following cycle; there is no accept on the handshake edge.
- resp_ready while not in RESP: ignored.
- req_valid while not in IDLE: ignored. No accept, no side effect.
- Reset mid-operation: a request in WAIT is abandoned with no RAM write, and any pending response is dropped.
- Address index: word index = (addr - BASE_ADDR)[31:2]. Wrap-around of the address arithmetic is never reached, because out-of-range addresses are rejected.

Decomposition:
- Shared package (mem_if_pkg):
  - Size encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - FSM state encoding: IDLE, WAIT, RESP.
  - Constants: WAIT counter width (4).
- Sub-module lane_align, combinational, containing all byte-steering logic:
  - Store path: produces the 4-bit byte enable and the shifted write word from addr[1:0], size and wdata.
  - Load path: produces the extended load value from the raw word, addr[1:0], size and signed.
  - The top level holds the FSM, the latched request, the counter and the RAM.

Test Plan:
1. Release reset, WAIT_CYCLES = 1 → req_ready = 1, resp_valid = 0. Load word 0x0000_0000 → resp_valid 2 cycles after accept, rdata = 0x0000_0000, err = 0.
2. Store word 0x10 = 0x8765_4321, then:
   - Load byte, signed, at 0x13 → 0xFFFF_FF87.
   - Load half, unsigned, at 0x10 → 0x0000_4321.
   - Load half, signed, at 0x12 → 0xFFFF_8765.
3. Store word 0x20 = 0x1122_3344, then store byte 0xAB at 0x21 → a word load at 0x20 returns 0x1122_AB44.
4. Load word at 0x22 (misaligned) → resp_valid the next cycle, err = 1, rdata = 0. Store half at 0x11 → err = 1, and a word load at 0x10 is unchanged.
5. Hold resp_ready = 0 for 3 cycles in RESP while driving req_valid = 1 → resp outputs stable, req_ready = 0, no second access. Raise resp_ready → IDLE, accept on the next cycle.
6. WAIT_CYCLES = 3: assert reset while a store of 0xDEAD_BEEF to 0x30 is in WAIT (counter = 2) → after reset a load of 0x30 returns 0x0000_0000 and resp_valid stays 0.
